// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;
   localparam int XLEN           = 32;
   localparam int DEF_NUM_LINES  = 64;
   localparam int DEF_LINE_WORDS = 4;
   localparam int OFF_W          = $clog2(DEF_LINE_WORDS);
   localparam int IDX_W          = $clog2(DEF_NUM_LINES);
   localparam int TAG_W          = XLEN - IDX_W - OFF_W - 2;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_e;
endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one write port for refill words, one combinational read port.
module icache_line_array
   import icache_pkg::*;
#(
   parameter int NUM_LINES  = DEF_NUM_LINES,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   localparam int OW = $clog2(LINE_WORDS),
   localparam int IW = $clog2(NUM_LINES),
   localparam int TW = XLEN - IW - OW - 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [IW-1:0]   w_idx,
   input  logic [OW-1:0]   w_slot,
   input  logic [TW-1:0]   w_tag,
   input  logic [XLEN-1:0] w_data,
   input  logic            w_last,
   input  logic [IW-1:0]   r_idx,
   input  logic [OW-1:0]   r_off,
   input  logic [TW-1:0]   r_tag,
   output logic            hit,
   output logic [XLEN-1:0] word
);
   logic [NUM_LINES-1:0] valid;
   logic [TW-1:0]        tag_mem  [NUM_LINES];
   logic [XLEN-1:0]      data_mem [NUM_LINES*LINE_WORDS];

   // A line stays invalid until its last word lands, so a partial refill never hits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (we) begin
         valid[w_idx] <= w_last;
      end
   end

   // NOTE: tag and data arrays carry no reset; the valid vector alone gates their use.
   always_ff @(posedge clk) begin
      if (we) begin
         data_mem[{w_idx, w_slot}] <= w_data;
         tag_mem[w_idx]            <= w_tag;
      end
   end

   assign hit  = valid[r_idx] && (tag_mem[r_idx] == r_tag);
   assign word = data_mem[{r_idx, r_off}];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, word-serial line refill, flush-safe.
module icache
   import icache_pkg::*;
#(
   parameter int NUM_LINES  = DEF_NUM_LINES,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            flush_in,
   input  logic            if_req_valid,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_req_ready,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_out,
   output logic            mc_req_valid,
   output logic [XLEN-1:0] mc_addr,
   input  logic            mc_word_valid,
   input  logic [XLEN-1:0] mc_word
);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = XLEN - IW - OW - 2;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, inst_out_d, mc_addr_d, look_pc, rd_word;
   logic [OW-1:0]   cnt_q, cnt_d;
   logic            drop_q, drop_d, inst_valid_d, mc_req_valid_d;
   logic            hit, we, last_word;
   logic            unused_pc_bits;

   // In IDLE the read port serves the incoming PC; otherwise the latched miss PC.
   assign look_pc        = (state_q == IDLE) ? if_pc : pc_q;
   assign last_word      = (cnt_q == OW'(LINE_WORDS - 1));
   assign we             = rdy_in && (state_q == REFILL) && mc_word_valid;
   assign if_req_ready   = (state_q == IDLE);
   assign unused_pc_bits = ^{if_pc[1:0], pc_q[1:0]};

   icache_line_array #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) u_array (
      .clk    (clk_in),
      .rst    (rst_in),
      .we     (we),
      .w_idx  (pc_q[IW+OW+1:OW+2]),
      .w_slot (cnt_q),
      .w_tag  (pc_q[XLEN-1:IW+OW+2]),
      .w_data (mc_word),
      .w_last (last_word),
      .r_idx  (look_pc[IW+OW+1:OW+2]),
      .r_off  (look_pc[OW+1:2]),
      .r_tag  (look_pc[XLEN-1:IW+OW+2]),
      .hit    (hit),
      .word   (rd_word)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      cnt_d          = cnt_q;
      drop_d         = drop_q;
      inst_valid_d   = 1'b0;
      inst_out_d     = inst_out;
      mc_req_valid_d = mc_req_valid;
      mc_addr_d      = mc_addr;
      case (state_q)
         IDLE: begin
            if (if_req_valid && !flush_in) begin
               if (hit) begin
                  inst_valid_d = 1'b1;
                  inst_out_d   = rd_word;
               end else begin
                  pc_d           = if_pc;
                  mc_req_valid_d = 1'b1;
                  mc_addr_d      = {if_pc[XLEN-1:OW+2], {(OW+2){1'b0}}};
                  state_d        = REFILL;
               end
            end
         end
         REFILL: begin
            if (flush_in) drop_d = 1'b1;
            if (mc_word_valid) begin
               cnt_d = cnt_q + OW'(1);
               if (last_word) begin
                  cnt_d          = '0;
                  mc_req_valid_d = 1'b0;
                  state_d        = RESPOND;
               end
            end
         end
         RESPOND: begin
            if (!drop_q && !flush_in) begin
               inst_valid_d = 1'b1;
               inst_out_d   = rd_word;
            end
            drop_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; rdy_in low freezes everything.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         cnt_q        <= '0;
         drop_q       <= 1'b0;
         inst_valid   <= 1'b0;
         inst_out     <= '0;
         mc_req_valid <= 1'b0;
         mc_addr      <= '0;
      end else if (rdy_in) begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         drop_q       <= drop_d;
         inst_valid   <= inst_valid_d;
         inst_out     <= inst_out_d;
         mc_req_valid <= mc_req_valid_d;
         mc_addr      <= mc_addr_d;
      end
   end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: expected words queued at issue, checked by an independent monitor.
module tb_icache;
   import icache_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        flush = 1'b0;
   logic        if_req_valid = 1'b0;
   logic [31:0] if_pc = '0;
   logic        if_req_ready;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic        mc_req_valid;
   logic [31:0] mc_addr;
   logic        mc_word_valid = 1'b0;
   logic [31:0] mc_word = '0;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_word;
   logic [31:0] w [4];

   icache dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .rdy_in        (rdy),
      .flush_in      (flush),
      .if_req_valid  (if_req_valid),
      .if_pc         (if_pc),
      .if_req_ready  (if_req_ready),
      .inst_valid    (inst_valid),
      .inst_out      (inst_out),
      .mc_req_valid  (mc_req_valid),
      .mc_addr       (mc_addr),
      .mc_word_valid (mc_word_valid),
      .mc_word       (mc_word)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc);
      int n = 0;
      while (!if_req_ready && n < 100) begin
         tick();
         n++;
      end
      if (!if_req_ready) begin
         checks++;
         failures++;
         $display("FAIL req_ready_timeout: if_req_ready=%b expected 1", if_req_ready);
      end
      if_req_valid = 1'b1;
      if_pc        = pc;
      tick();
      if_req_valid = 1'b0;
   endtask

   task automatic send_words(input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         mc_word_valid = 1'b1;
         mc_word       = w[i];
         tick();
      end
      mc_word_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_if_req_ready"}, {31'b0, if_req_ready}, 32'd1);
      check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
      check({tag, "_inst_out"}, inst_out, 32'd0);
      check({tag, "_mc_req_valid"}, {31'b0, mc_req_valid}, 32'd0);
      check({tag, "_mc_addr"}, mc_addr, 32'd0);
   endtask

   // Scoreboard monitor: every inst_valid pulse must match the oldest queued word.
   always @(negedge clk) begin
      if (!rst && inst_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_inst_valid: got inst_out=%h with no pending request", inst_out);
         end else begin
            exp_word = exp_q.pop_front();
            check("inst_out", inst_out, exp_word);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Cold miss at 0x8, answer is word 2 of the line.
      w = '{NOP, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
      exp_q.push_back(32'h0020_0113);
      issue(32'h0000_0008);
      check("cold_mc_req_valid", {31'b0, mc_req_valid}, 32'd1);
      check("cold_mc_addr", mc_addr, 32'h0000_0000);
      check("cold_if_req_ready", {31'b0, if_req_ready}, 32'd0);
      send_words(0, 4);
      check("cold_mc_req_drop", {31'b0, mc_req_valid}, 32'd0);
      check("cold_respond_no_valid_yet", {31'b0, inst_valid}, 32'd0);
      tick();
      check("cold_inst_valid", {31'b0, inst_valid}, 32'd1);
      check("cold_inst_out", inst_out, 32'h0020_0113);
      tick();
      check("cold_single_pulse", {31'b0, inst_valid}, 32'd0);
      check("cold_ready_back", {31'b0, if_req_ready}, 32'd1);

      // Back-to-back hits.
      exp_q.push_back(NOP);
      exp_q.push_back(32'h0010_0093);
      exp_q.push_back(32'h0030_0193);
      if_req_valid = 1'b1;
      if_pc = 32'h0;
      tick();
      check("hit0_valid", {31'b0, inst_valid}, 32'd1);
      if_pc = 32'h4;
      tick();
      check("hit1_valid", {31'b0, inst_valid}, 32'd1);
      if_pc = 32'hC;
      tick();
      check("hit2_valid", {31'b0, inst_valid}, 32'd1);
      check("hit_no_mc_req", {31'b0, mc_req_valid}, 32'd0);
      if_req_valid = 1'b0;
      tick();

      // Flush together with a request in IDLE: request dropped.
      if_req_valid = 1'b1;
      if_pc = 32'h4;
      flush = 1'b1;
      tick();
      if_req_valid = 1'b0;
      flush = 1'b0;
      check("idle_flush_no_valid", {31'b0, inst_valid}, 32'd0);
      check("idle_flush_no_mc_req", {31'b0, mc_req_valid}, 32'd0);
      tick();

      // Conflict eviction: 0x400 maps to line 0 with a new tag.
      w = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
      exp_q.push_back(32'hA000_0000);
      issue(32'h0000_0400);
      check("evict_mc_req_valid", {31'b0, mc_req_valid}, 32'd1);
      check("evict_mc_addr", mc_addr, 32'h0000_0400);
      send_words(0, 4);
      tick();
      tick();
      w = '{NOP, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
      exp_q.push_back(NOP);
      issue(32'h0000_0000);
      check("evicted_miss_mc_req", {31'b0, mc_req_valid}, 32'd1);
      check("evicted_miss_mc_addr", mc_addr, 32'h0000_0000);
      send_words(0, 4);
      tick();
      tick();

      // Flush mid-refill: burst completes, no answer, line becomes valid.
      w = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
      issue(32'h0000_1000);
      send_words(0, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_mc_req_held", {31'b0, mc_req_valid}, 32'd1);
      send_words(2, 1);
      check("flush_still_refilling", {31'b0, mc_req_valid}, 32'd1);
      send_words(3, 1);
      check("flush_refill_done", {31'b0, mc_req_valid}, 32'd0);
      tick();
      check("flush_dropped_answer", {31'b0, inst_valid}, 32'd0);
      tick();
      exp_q.push_back(32'hD000_0000);
      issue(32'h0000_1000);
      check("flush_line_hit_1cyc", {31'b0, inst_valid}, 32'd1);
      check("flush_line_no_mc_req", {31'b0, mc_req_valid}, 32'd0);
      tick();

      // rdy_in low for 5 cycles after the first refill word.
      w = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
      exp_q.push_back(32'hB000_0001);
      issue(32'h0000_2004);
      check("stall_mc_addr", mc_addr, 32'h0000_2000);
      send_words(0, 1);
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_mc_req_held", {31'b0, mc_req_valid}, 32'd1);
         check("stall_ready_low", {31'b0, if_req_ready}, 32'd0);
         check("stall_no_valid", {31'b0, inst_valid}, 32'd0);
      end
      rdy = 1'b1;
      send_words(1, 3);
      check("stall_refill_done", {31'b0, mc_req_valid}, 32'd0);
      tick();
      check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
      tick();

      // Async reset after the 2nd refill word.
      w = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
      issue(32'h0000_3008);
      send_words(0, 2);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      tick();
      #2;
      rst = 1'b0;
      tick();
      exp_q.push_back(32'hC000_0002);
      issue(32'h0000_3008);
      check("postrst_miss_mc_req", {31'b0, mc_req_valid}, 32'd1);
      check("postrst_miss_mc_addr", mc_addr, 32'h0000_3000);
      send_words(0, 4);
      tick();
      tick();
      tick();

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the instruction-fetch stage.
- Takes PC lookups from IF and returns 32-bit instruction words that IF pushes into its instruction queue.
- On a miss, refills a full line from the memory controller one 32-bit word at a time, then answers IF.
- Supports a flush (branch mispredict) that discards the in-flight answer without corrupting cache contents.

Parameters:
- NUM_LINES, 64, number of cache lines; power of 2, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk_in  input  1  system clock; only clock.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global ready; when low, all state and outputs hold.
- flush_in  input  1  discard the current/pending IF request.
- if_req_valid  input  1  IF presents a fetch address.
- if_pc  input  32  fetch address; bits [1:0] ignored.
- if_req_ready  output  1  cache can accept a request this cycle.
- inst_valid  output  1  single-cycle pulse: inst_out is valid.
- inst_out  output  32  instruction word for the accepted PC.
- mc_req_valid  output  1  refill request to the memory controller.
- mc_addr  output  32  line-aligned refill base address.
- mc_word_valid  input  1  memory controller delivers one word.
- mc_word  input  32  refill data word, ascending address order.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS); IDX = log2(NUM_LINES).
  - word offset = pc[OFF+1:2]; index = pc[IDX+OFF+1:OFF+2]; tag = pc[31:IDX+OFF+2].
- Storage:
  - per line: valid bit, tag, LINE_WORDS data words.
  - reset clears all valid bits; data is not reset.
- Reset (async, any state, including mid-refill):
  - state = IDLE.
  - if_req_ready = 1, inst_valid = 0, inst_out = 0.
  - mc_req_valid = 0, mc_addr = 0, word counter = 0, drop flag = 0.
  - A partially filled line is never marked valid.
- rdy_in low: no state, counter, array or output changes. The memory controller is also stalled by rdy_in, so mc_word_valid is never asserted while rdy_in is low.
- States:
  - IDLE: if_req_ready = 1. A request is accepted when if_req_valid & rdy_in & !flush_in.
    - Hit: next cycle inst_valid = 1 and inst_out = the addressed word (1-cycle latency). Stay in IDLE, so back-to-back hits give one result per cycle.
    - Miss: latch pc. Next cycle mc_req_valid = 1 and mc_addr = {pc[31:OFF+2], (OFF+2)'b0}; go to REFILL.
  - REFILL: if_req_ready = 0 and mc_req_valid is held high.
    - Each mc_word_valid writes mc_word into slot[counter] of the indexed line and increments the counter.
    - On the word with counter == LINE_WORDS-1: write tag, set valid, drop mc_req_valid next cycle, clear the counter, go to RESPOND.
  - RESPOND (1 cycle):
    - drop flag clear: inst_valid = 1, inst_out = latched-offset word.
    - drop flag set: inst_valid = 0 and the drop flag is cleared.
    - Go to IDLE; if_req_ready returns to 1 the following cycle.
- Flush:
  - Flush in IDLE suppresses any inst_valid due next cycle. A request in the same cycle is not accepted; flush wins.
  - Flush in REFILL sets the drop flag. The refill still completes so the memory protocol is never aborted mid-burst, and the line becomes valid.
  - Flush in RESPOND suppresses that cycle's inst_valid.
- Misc:
  - inst_valid is never high for two cycles for one accepted request.
  - inst_out holds its last value when inst_valid = 0.
  - A new conflicting miss overwrites the line (no replacement choice).

Decomposition:
- Shared package (icache_pkg):
  - state enum {IDLE, REFILL, RESPOND}.
  - localparams OFF_W, IDX_W, TAG_W derived from the parameters.
  - XLEN = 32.
  - the RISC-V NOP constant 32'h0000_0013 (used by the bench).
- One natural sub-module: icache_line_array. It holds the valid/tag/data storage, has an async-clear valid vector, one write port (index, word slot, tag/valid update) and one combinational read port (index, offset). It returns {hit, word}.

Test Plan:
- Cold miss: reset, then request pc=0x0000_0008 → mc_req_valid = 1 with mc_addr = 0x0000_0000. Deliver words 0x00000013, 0x00100093, 0x00200113, 0x00300193 → inst_valid = 1 with inst_out = 0x00200113 exactly one cycle after RESPOND entry.
- Hit streaming: after the cold miss, requests pc = 0x0, 0x4, 0xC on consecutive cycles → inst_valid on three consecutive cycles with 0x00000013, 0x00100093, 0x00300193. mc_req_valid stays 0.
- Conflict eviction: request pc=0x0000_0400 (same index, new tag) → refill with mc_addr = 0x400. Afterwards pc=0x0 misses again.
- Flush mid-refill: miss on pc=0x0000_1000, flush_in high for one cycle after the 2nd word → all 4 words are still consumed and no inst_valid occurs. A later request to pc=0x1000 hits in 1 cycle.
- rdy_in low mid-refill: after the 1st word, hold rdy_in = 0 for 5 cycles → counter, state and outputs frozen. After release, the refill resumes and completes with correct data.
- Reset mid-refill: assert rst_in after the 2nd word → outputs go to their reset values immediately (async). A subsequent request to the same PC misses and triggers a full refill.
